// File: rtl/nes_pad_poller_if.sv
// Bus between the pad poller, the game-side consumers and the pad connector pins.
// The slave modport is the poller's view; the master modport is the host and pad side.
interface nes_pad_poller_if #(
  parameter int unsigned NUM_PADS = 1,
  parameter int unsigned NUM_BITS = 8
);
  logic                         poll;
  logic [NUM_PADS-1:0]          nes_data;
  logic                         nes_latch;
  logic                         nes_clk;
  logic [NUM_PADS*NUM_BITS-1:0] buttons;
  logic [NUM_PADS*NUM_BITS-1:0] pressed;
  logic [NUM_PADS-1:0]          pad_present;
  logic                         valid;
  logic                         busy;
  logic                         poll_dropped;

  modport slave (
    input  poll,
    input  nes_data,
    output nes_latch,
    output nes_clk,
    output buttons,
    output pressed,
    output pad_present,
    output valid,
    output busy,
    output poll_dropped
  );

  modport master (
    output poll,
    output nes_data,
    input  nes_latch,
    input  nes_clk,
    input  buttons,
    input  pressed,
    input  pad_present,
    input  valid,
    input  busy,
    input  poll_dropped
  );
endinterface

// File: rtl/nes_pad_poller.sv
// NES/SNES serial pad poller: on each poll it latches all pads, clocks NUM_BITS
// bits in from every data line and publishes per-frame button, edge and presence words.
module nes_pad_poller #(
  parameter int unsigned NUM_PADS     = 1,
  parameter int unsigned NUM_BITS     = 8,
  parameter int unsigned CLK_DIV      = 75,
  parameter int unsigned LATCH_CYCLES = 300
) (
  input  logic                clk,
  input  logic                rst_n,
  nes_pad_poller_if.slave     bus
);

  // One counter serves both the latch phase and each clock half-period.
  localparam int unsigned CNT_MAX = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] BIT_LAST   = IDX_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_CLK_LO = 3'd2,
    S_CLK_HI = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  typedef logic [NUM_PADS-1:0][NUM_BITS-1:0] word_arr_t;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                nes_latch_q, nes_latch_d;
  logic                nes_clk_q, nes_clk_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                dropped_q, dropped_d;

  logic [NUM_PADS-1:0] sync1_q, sync2_q;
  word_arr_t           shreg_q, shreg_d;
  word_arr_t           buttons_q, buttons_d;
  word_arr_t           pressed_q, pressed_d;
  logic [NUM_PADS-1:0] present_q, present_d;

  logic                sample_c;
  logic                done_c;

  // Next-state and registered pin/status outputs, all derived from the next state.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    sample_c       = 1'b0;
    done_c         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.poll) begin
          state_d = S_LATCH;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = S_CLK_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CLK_LO: begin
        if (cnt_q == HALF_LAST) begin
          sample_c = 1'b1;
          state_d  = S_CLK_HI;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CLK_HI: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (idx_q == BIT_LAST) begin
            state_d = S_DONE;
            done_c  = 1'b1;
          end else begin
            state_d = S_CLK_LO;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    nes_latch_d = (state_d == S_LATCH);
    nes_clk_d   = (state_d == S_CLK_HI);
    valid_d     = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    dropped_d   = bus.poll && (state_q != S_IDLE);
  end

  // Shift capture and the atomic end-of-frame update of the published words.
  always_comb begin
    shreg_d   = shreg_q;
    buttons_d = buttons_q;
    pressed_d = pressed_q;
    present_d = present_q;

    if (sample_c) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        shreg_d[p][idx_q] = sync2_q[p];
      end
    end

    // An all-zero raw word means the line never went high: pad absent or stuck.
    if (done_c) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        present_d[p] = |shreg_q[p];
        buttons_d[p] = present_d[p] ? ~shreg_q[p] : '0;
        pressed_d[p] = buttons_d[p] & ~buttons_q[p];
      end
    end
  end

  // FSM state, counters and pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      nes_latch_q <= 1'b0;
      nes_clk_q   <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      nes_latch_q <= nes_latch_d;
      nes_clk_q   <= nes_clk_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      dropped_q   <= dropped_d;
    end
  end

  // Data-line synchronisers, shift registers and published words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      shreg_q   <= '0;
      buttons_q <= '0;
      pressed_q <= '0;
      present_q <= '0;
    end else begin
      sync1_q   <= bus.nes_data;
      sync2_q   <= sync1_q;
      shreg_q   <= shreg_d;
      buttons_q <= buttons_d;
      pressed_q <= pressed_d;
      present_q <= present_d;
    end
  end

  assign bus.nes_latch    = nes_latch_q;
  assign bus.nes_clk      = nes_clk_q;
  assign bus.valid        = valid_q;
  assign bus.busy         = busy_q;
  assign bus.poll_dropped = dropped_q;
  assign bus.buttons      = buttons_q;
  assign bus.pressed      = pressed_q;
  assign bus.pad_present  = present_q;

endmodule

// File: tb/tb_nes_pad_poller.sv
// Bench for nes_pad_poller: a default NES instance and a fast two-pad SNES instance,
// each fed by a behavioural shift-register pad and checked against a frame-level model.
module tb_nes_pad_poller;

  localparam int A_PADS = 1, A_BITS = 8,  A_DIV = 75, A_LAT = 300;
  localparam int B_PADS = 2, B_BITS = 16, B_DIV = 2,  B_LAT = 3;
  localparam int A_VALID_AT = A_LAT + 2 * A_BITS * A_DIV + 1;
  localparam int B_VALID_AT = B_LAT + 2 * B_BITS * B_DIV + 1;

  logic clk = 1'b0;
  logic rst_a_n = 1'b1;
  logic rst_b_n = 1'b1;
  always #5 clk = ~clk;

  nes_pad_poller_if #(.NUM_PADS(A_PADS), .NUM_BITS(A_BITS)) if_a ();
  nes_pad_poller_if #(.NUM_PADS(B_PADS), .NUM_BITS(B_BITS)) if_b ();

  nes_pad_poller #(.NUM_PADS(A_PADS), .NUM_BITS(A_BITS), .CLK_DIV(A_DIV), .LATCH_CYCLES(A_LAT))
    u_dut_a (.clk(clk), .rst_n(rst_a_n), .bus(if_a));
  nes_pad_poller #(.NUM_PADS(B_PADS), .NUM_BITS(B_BITS), .CLK_DIV(B_DIV), .LATCH_CYCLES(B_LAT))
    u_dut_b (.clk(clk), .rst_n(rst_b_n), .bus(if_b));

  // Pad models: load the inverted button word on latch, shift on each nes_clk rise.
  logic [7:0]  word_a  = 8'h00;
  logic [7:0]  sh_a    = 8'hFF;
  logic [15:0] word_b0 = 16'h0000;
  logic [15:0] word_b1 = 16'h0000;
  logic [15:0] sh_b0   = 16'hFFFF;
  logic [15:0] sh_b1   = 16'hFFFF;
  logic        stuck1  = 1'b0;

  always @(posedge if_a.nes_latch or posedge if_a.nes_clk) begin
    if (if_a.nes_latch) sh_a <= ~word_a;
    else                sh_a <= {1'b1, sh_a[7:1]};
  end

  always @(posedge if_b.nes_latch or posedge if_b.nes_clk) begin
    if (if_b.nes_latch) begin
      sh_b0 <= ~word_b0;
      sh_b1 <= ~word_b1;
    end else begin
      sh_b0 <= {1'b1, sh_b0[15:1]};
      sh_b1 <= {1'b1, sh_b1[15:1]};
    end
  end

  assign if_a.nes_data = sh_a[0];
  assign if_b.nes_data = {(stuck1 ? 1'b0 : sh_b1[0]), sh_b0[0]};

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model state: last published button words.
  logic [7:0]  prev_a  = 8'h00;
  logic [15:0] prev_b0 = 16'h0000;
  logic [15:0] prev_b1 = 16'h0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poll_a(input logic [7:0] w, input int drop_at);
    logic [7:0] e_btn, e_prs, got_btn, got_prs;
    logic       e_pres, got_pres, busy_v, last_clk;
    int lat_n, clk_in_lat, rises, nvalid, valid_at, ndrop;
    e_pres = (w != 8'hFF);
    e_btn  = e_pres ? w : 8'h00;
    e_prs  = e_btn & ~prev_a;
    prev_a = e_btn;
    word_a = w;
    lat_n = 0; clk_in_lat = 0; rises = 0; nvalid = 0; valid_at = -1; ndrop = 0;
    last_clk = 1'b0; got_btn = 8'h00; got_prs = 8'h00; got_pres = 1'b0; busy_v = 1'b0;
    @(posedge clk); #1 if_a.poll = 1'b1;
    @(posedge clk); #1 if_a.poll = 1'b0;
    check("a_busy_start", 64'(if_a.busy), 64'd1);
    for (int k = 1; k <= A_VALID_AT + 6; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (if_a.nes_latch) begin
        lat_n++;
        if (if_a.nes_clk) clk_in_lat++;
      end
      if (if_a.nes_clk && !last_clk) rises++;
      last_clk = if_a.nes_clk;
      if (if_a.poll_dropped) ndrop++;
      if (if_a.valid) begin
        nvalid++;
        if (valid_at < 0) begin
          valid_at = k;
          got_btn  = if_a.buttons;
          got_prs  = if_a.pressed;
          got_pres = if_a.pad_present[0];
          busy_v   = if_a.busy;
        end
      end
      if (drop_at > 0 && k == drop_at) if_a.poll = 1'b1;
      if (drop_at > 0 && k == drop_at + 1) begin
        if_a.poll = 1'b0;
        check("a_poll_dropped_pulse", 64'(if_a.poll_dropped), 64'd1);
      end
    end
    check("a_valid_cycle",   64'(valid_at),   64'(A_VALID_AT));
    check("a_valid_count",   64'(nvalid),     64'd1);
    check("a_latch_cycles",  64'(lat_n),      64'(A_LAT));
    check("a_clk_in_latch",  64'(clk_in_lat), 64'd0);
    check("a_clk_rises",     64'(rises),      64'(A_BITS));
    check("a_drop_count",    64'(ndrop),      64'((drop_at > 0) ? 1 : 0));
    check("a_busy_at_valid", 64'(busy_v),     64'd1);
    check("a_buttons",       64'(got_btn),    64'(e_btn));
    check("a_pressed",       64'(got_prs),    64'(e_prs));
    check("a_present",       64'(got_pres),   64'(e_pres));
    check("a_busy_end",      64'(if_a.busy),  64'd0);
  endtask

  task automatic poll_b(input logic [15:0] w0, input logic [15:0] w1, input logic stk);
    logic [15:0] eff1, e_btn0, e_btn1;
    logic [31:0] e_btn, e_prs;
    logic [1:0]  e_pres;
    int nvalid, valid_at, rises;
    logic last_clk;
    eff1      = stk ? 16'hFFFF : w1;
    e_pres[0] = (w0 != 16'hFFFF);
    e_pres[1] = (eff1 != 16'hFFFF);
    e_btn0    = e_pres[0] ? w0 : 16'h0000;
    e_btn1    = e_pres[1] ? eff1 : 16'h0000;
    e_btn     = {e_btn1, e_btn0};
    e_prs     = {e_btn1 & ~prev_b1, e_btn0 & ~prev_b0};
    prev_b0   = e_btn0;
    prev_b1   = e_btn1;
    word_b0 = w0; word_b1 = w1; stuck1 = stk;
    nvalid = 0; valid_at = -1; rises = 0; last_clk = 1'b0;
    @(posedge clk); #1 if_b.poll = 1'b1;
    @(posedge clk); #1 if_b.poll = 1'b0;
    for (int k = 1; k <= B_VALID_AT + 4; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (if_b.nes_clk && !last_clk) rises++;
      last_clk = if_b.nes_clk;
      if (if_b.valid) begin
        nvalid++;
        if (valid_at < 0) begin
          valid_at = k;
          check("b_buttons", 64'(if_b.buttons),     64'(e_btn));
          check("b_pressed", 64'(if_b.pressed),     64'(e_prs));
          check("b_present", 64'(if_b.pad_present), 64'(e_pres));
        end
      end
    end
    check("b_valid_cycle", 64'(valid_at), 64'(B_VALID_AT));
    check("b_valid_count", 64'(nvalid),   64'd1);
    check("b_clk_rises",   64'(rises),    64'(B_BITS));
  endtask

  initial begin
    int stray_valid;
    if_a.poll = 1'b0;
    if_b.poll = 1'b0;
    #2 rst_a_n = 1'b0; rst_b_n = 1'b0;
    #1;
    check("rst_a_latch",   64'(if_a.nes_latch), 64'd0);
    check("rst_a_clk",     64'(if_a.nes_clk),   64'd0);
    check("rst_a_buttons", 64'(if_a.buttons),   64'd0);
    check("rst_a_status",  64'({if_a.valid, if_a.busy, if_a.poll_dropped, if_a.pad_present}), 64'd0);
    check("rst_b_outputs", 64'({if_b.buttons, if_b.pressed, if_b.pad_present, if_b.valid, if_b.busy}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_a_n = 1'b1; rst_b_n = 1'b1;

    // Default NES instance: directed press/release sequence, then a dropped poll.
    poll_a(8'h05, 0);
    poll_a(8'h05, 10);
    poll_a(8'h04, 0);
    poll_a(8'h06, 0);
    poll_a(8'hFF, 0);
    poll_a(8'($urandom), 0);

    // Two-pad SNES instance: absent second pad, then randomized frames.
    poll_b(16'($urandom), 16'h1234, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] r0, r1;
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r1 = 16'hFFFF;
      if ($urandom_range(0, 5) == 0) r0 = 16'h0000;
      poll_b(r0, r1, 1'b0);
    end
    poll_b(16'h00F3, 16'h8001, 1'b0);

    // Reset during the high half of bit 3.
    @(posedge clk); #1 if_b.poll = 1'b1;
    @(posedge clk); #1 if_b.poll = 1'b0;
    repeat (B_LAT + 2 * 3 * B_DIV + B_DIV) @(posedge clk);
    #1;
    check("b_pre_reset_clk_high", 64'(if_b.nes_clk), 64'd1);
    rst_b_n = 1'b0;
    #1;
    check("b_rst_clk",     64'(if_b.nes_clk),   64'd0);
    check("b_rst_latch",   64'(if_b.nes_latch), 64'd0);
    check("b_rst_buttons", 64'(if_b.buttons),   64'd0);
    check("b_rst_busy",    64'(if_b.busy),      64'd0);
    prev_b0 = 16'h0000;
    prev_b1 = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst_b_n = 1'b1;
    stray_valid = 0;
    for (int k = 0; k < 2 * B_VALID_AT; k++) begin
      @(posedge clk); #1;
      if (if_b.valid) stray_valid++;
    end
    check("b_no_valid_after_reset", 64'(stray_valid), 64'd0);
    poll_b(16'h0A0C, 16'h0001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
